// File: rtl/tcp_segment_tx.sv
// tcp_segment_tx
// Builds one Ethernet II / IPv4 / TCP frame per request and streams it out
// one byte per clock with no gaps.  The payload is buffered first so the TCP
// checksum is complete before the header is emitted.
//
// Ports
//   CLOCK, RESET        clock, asynchronous active-high reset
//   start, len          request pulse (sampled in IDLE) and payload length
//   src_ip .. window    header fields, latched on an accepted start
//   inValid/inData      payload byte input, accepted when inValid & inReady
//   inReady             high while payload bytes are being collected
//   dataValid/data      output byte stream, continuous for a whole frame
//   newpkt/lastByte     first / final byte markers
//   busy                request in progress
//   error               one-cycle pulse after a start with len > max_payload
module tcp_segment_tx #(
    parameter logic [47:0] mac         = 48'hC471FEC856BF,
    parameter logic [47:0] dst_mac     = 48'h001122334455,
    parameter int          max_payload = 64,
    parameter logic [7:0]  ttl         = 8'd64
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        start,
    input  logic [6:0]  len,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [31:0] seq,
    input  logic [31:0] ack,
    input  logic [7:0]  flags,
    input  logic [15:0] window,
    input  logic        inValid,
    input  logic [7:0]  inData,
    output logic        inReady,
    output logic        dataValid,
    output logic [7:0]  data,
    output logic        newpkt,
    output logic        lastByte,
    output logic        busy,
    output logic        error
);
    localparam int         AW      = (max_payload > 1) ? $clog2(max_payload) : 1;
    localparam int         DEPTH   = 1 << AW;
    localparam logic [6:0] MAX_LEN = 7'(max_payload);

    typedef enum logic [2:0] {IDLE, LOAD, FOLD1, FOLD2, EMIT} state_t;

    state_t      state_r, state_s;
    logic [31:0] src_ip_r, dst_ip_r, seq_r, ack_r;
    logic [15:0] src_port_r, dst_port_r, window_r, id_r;
    logic [7:0]  flags_r, idx_r, data_r;
    logic [6:0]  len_r, k_r;
    logic [23:0] tcp_sum_r, ip_sum_r;
    logic        inready_r, dvalid_r, newpkt_r, last_r, busy_r, error_r;
    logic [7:0]  buffer_r [0:DEPTH-1];

    logic        start_ok_s, reject_s, accept_s, last_accept_s;
    logic [15:0] len16_s, tot_len_s;
    logic [23:0] hdr_sum_s, ip_hdr_sum_s, pay_word_s;
    logic [7:0]  raw_len_s, frame_len_s, byte_s;
    logic [5:0]  hdr_idx_s;
    logic [6:0]  pay_idx_s;
    logic [431:0] hdr_s;

    // End-around carry fold of a wide one's-complement accumulator.
    function automatic logic [23:0] fold(input logic [23:0] s);
        return {8'h00, s[15:0]} + {16'h0000, s[23:16]};
    endfunction

    assign len16_s   = {9'd0, len};
    assign tot_len_s = 16'd40 + {9'd0, len_r};

    // Pseudo-header plus TCP header (checksum and urgent fields are zero),
    // taken straight from the inputs so the accumulator is seeded at start.
    assign hdr_sum_s = 24'(src_ip[31:16]) + 24'(src_ip[15:0])
                     + 24'(dst_ip[31:16]) + 24'(dst_ip[15:0])
                     + 24'h000006 + 24'(16'd20 + len16_s)
                     + 24'(src_port) + 24'(dst_port)
                     + 24'(seq[31:16]) + 24'(seq[15:0])
                     + 24'(ack[31:16]) + 24'(ack[15:0])
                     + 24'({8'h50, flags}) + 24'(window);

    // IPv4 header words with the checksum field zero; id is the current counter.
    assign ip_hdr_sum_s = 24'h004500 + 24'(16'd40 + len16_s) + 24'(id_r)
                        + 24'h004000 + 24'({ttl, 8'h06})
                        + 24'(src_ip[31:16]) + 24'(src_ip[15:0])
                        + 24'(dst_ip[31:16]) + 24'(dst_ip[15:0]);

    // Even byte index lands in the high half of a word, odd in the low half.
    assign pay_word_s    = k_r[0] ? {16'h0000, inData} : {8'h00, inData, 8'h00};
    assign accept_s      = (state_r == LOAD) && inready_r && inValid;
    assign last_accept_s = accept_s && (k_r == (len_r - 7'd1));

    assign raw_len_s   = 8'd54 + {1'b0, len_r};
    assign frame_len_s = (raw_len_s < 8'd60) ? 8'd60 : raw_len_s;

    assign hdr_s = {dst_mac, mac, 16'h0800,
                    16'h4500, tot_len_s, id_r, 16'h4000, ttl, 8'h06,
                    ~ip_sum_r[15:0], src_ip_r, dst_ip_r,
                    src_port_r, dst_port_r, seq_r, ack_r, 8'h50, flags_r,
                    window_r, ~tcp_sum_r[15:0], 16'h0000};

    assign hdr_idx_s = 6'(8'd53 - idx_r);
    assign pay_idx_s = 7'(idx_r - 8'd54);

    // Select the frame byte at idx_r: header, buffered payload, or zero pad.
    always_comb begin
        byte_s = 8'h00;
        if (idx_r < 8'd54) begin
            byte_s = hdr_s[{hdr_idx_s, 3'b000} +: 8];
        end else if (pay_idx_s < len_r) begin
            byte_s = buffer_r[pay_idx_s[AW-1:0]];
        end else begin
            byte_s = 8'h00;
        end
    end

    // Next-state decode and start qualification.
    always_comb begin
        state_s    = state_r;
        start_ok_s = 1'b0;
        reject_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len > MAX_LEN) begin
                        reject_s = 1'b1;
                        state_s  = IDLE;
                    end else begin
                        start_ok_s = 1'b1;
                        state_s    = (len == 7'd0) ? FOLD1 : LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD:    state_s = last_accept_s ? FOLD1 : LOAD;
            FOLD1:   state_s = FOLD2;
            FOLD2:   state_s = EMIT;
            EMIT:    state_s = (idx_r == frame_len_s) ? IDLE : EMIT;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Payload buffer; contents are don't-care until rewritten, so no reset.
    always_ff @(posedge CLOCK) begin
        if (accept_s) begin
            buffer_r[k_r[AW-1:0]] <= inData;
        end
    end

    // Field latches, checksum accumulators, id counter and registered outputs.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            src_ip_r   <= 32'd0;
            dst_ip_r   <= 32'd0;
            seq_r      <= 32'd0;
            ack_r      <= 32'd0;
            src_port_r <= 16'd0;
            dst_port_r <= 16'd0;
            window_r   <= 16'd0;
            flags_r    <= 8'd0;
            len_r      <= 7'd0;
            k_r        <= 7'd0;
            idx_r      <= 8'd0;
            id_r       <= 16'd0;
            tcp_sum_r  <= 24'd0;
            ip_sum_r   <= 24'd0;
            inready_r  <= 1'b0;
            dvalid_r   <= 1'b0;
            data_r     <= 8'd0;
            newpkt_r   <= 1'b0;
            last_r     <= 1'b0;
            busy_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            error_r <= reject_s;
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        src_ip_r   <= src_ip;
                        dst_ip_r   <= dst_ip;
                        seq_r      <= seq;
                        ack_r      <= ack;
                        src_port_r <= src_port;
                        dst_port_r <= dst_port;
                        window_r   <= window;
                        flags_r    <= flags;
                        len_r      <= len;
                        k_r        <= 7'd0;
                        idx_r      <= 8'd0;
                        tcp_sum_r  <= hdr_sum_s;
                        ip_sum_r   <= ip_hdr_sum_s;
                        busy_r     <= 1'b1;
                        inready_r  <= (len != 7'd0);
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        tcp_sum_r <= tcp_sum_r + pay_word_s;
                        k_r       <= k_r + 7'd1;
                        if (last_accept_s) begin
                            inready_r <= 1'b0;
                        end
                    end
                end
                FOLD1: begin
                    tcp_sum_r <= fold(tcp_sum_r);
                    ip_sum_r  <= fold(ip_sum_r);
                end
                FOLD2: begin
                    // Second fold completes both checksums; byte 0 is MAC
                    // and needs neither, so it can be loaded on this edge.
                    tcp_sum_r <= fold(tcp_sum_r);
                    ip_sum_r  <= fold(ip_sum_r);
                    dvalid_r  <= 1'b1;
                    data_r    <= byte_s;
                    newpkt_r  <= 1'b1;
                    last_r    <= 1'b0;
                    idx_r     <= 8'd1;
                end
                EMIT: begin
                    if (idx_r == frame_len_s) begin
                        dvalid_r <= 1'b0;
                        data_r   <= 8'd0;
                        newpkt_r <= 1'b0;
                        last_r   <= 1'b0;
                        busy_r   <= 1'b0;
                        id_r     <= id_r + 16'd1;
                    end else begin
                        dvalid_r <= 1'b1;
                        data_r   <= byte_s;
                        newpkt_r <= 1'b0;
                        last_r   <= (idx_r == (frame_len_s - 8'd1));
                        idx_r    <= idx_r + 8'd1;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign inReady   = inready_r;
    assign dataValid = dvalid_r;
    assign data      = data_r;
    assign newpkt    = newpkt_r;
    assign lastByte  = last_r;
    assign busy      = busy_r;
    assign error     = error_r;

endmodule

// File: doc/tcp_segment_tx.md
# tcp_segment_tx

Transmit-side counterpart to the Tcp receive filter. It builds one complete Ethernet II / IPv4 / TCP frame per request and emits it as a byte stream using the same signalling the receive path consumes: `dataValid`, `data` and `newpkt`, one byte per clock with no gaps. Payload is buffered internally so that the TCP checksum can be computed before emission. The output can loop straight back into a Tcp instance for self-checking.

## Interface
Parameters:
- `mac`, 48'hC471FEC856BF, source MAC address.
- `dst_mac`, 48'h001122334455, destination MAC address.
- `max_payload`, 64, payload buffer depth in bytes (1..127).
- `ttl`, 8'd64, IPv4 TTL.

Ports:
- `CLOCK`  in  1  sole clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `len`  in  7  payload length, 0..`max_payload`.
- `src_ip`, `dst_ip`  in  32  IPv4 addresses, latched at start.
- `src_port`, `dst_port`  in  16  TCP ports, latched at start.
- `seq`, `ack`  in  32  sequence and acknowledgement numbers, latched at start.
- `flags`  in  8  TCP flags byte, latched at start.
- `window`  in  16  TCP window, latched at start.
- `inValid`  in  1  payload byte valid.
- `inData`  in  8  payload byte.
- `inReady`  out  1  payload byte accepted when `inValid & inReady`.
- `dataValid`  out  1  output byte valid.
- `data`  out  8  output byte.
- `newpkt`  out  1  high with the first byte of each frame.
- `lastByte`  out  1  high with the final byte of each frame.
- `busy`  out  1  request in progress.
- `error`  out  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, LOAD, FOLD1, FOLD2, EMIT.
- IDLE: on `start`, latch all header fields.
  - If `len > max_payload`: pulse `error` for one cycle, stay in IDLE, emit nothing.
  - If `len == 0`: go to FOLD1.
  - Otherwise: go to LOAD.
- LOAD:
  - `inReady` = 1.
  - Each accepted byte is written to buffer[k] and added to the checksum accumulator. Even k feeds the high byte of a 16-bit word, odd k the low byte.
  - After `len` bytes are accepted, go to FOLD1. An odd final byte is padded with 0x00 in the low byte.
- Checksum accumulator: at least 24 bits wide, zeroed at start. The sum covers:
  - the pseudo-header: src_ip, dst_ip, 0x0006, TCP length = 20+len;
  - the TCP header words with the checksum field set to 0;
  - the payload.
- FOLD1 and FOLD2 each fold carries: sum = sum[15:0] + sum[23:16]. The TCP checksum is ~sum[15:0].
- The IPv4 header checksum is computed the same way over the 10 header words with the checksum field set to 0. It is ready by the end of FOLD2.
- EMIT: one byte per cycle, in this order:
  - bytes 0..13: dst_mac, mac, 0x0800;
  - bytes 14..33: 45 00, total length (40+len), id, 40 00, ttl, 06, IP checksum, src_ip, dst_ip;
  - bytes 34..53: src_port, dst_port, seq, ack, 50, flags, window, TCP checksum, 00 00;
  - then the payload, then 0x00 padding up to 60 bytes.
- Frame length = max(54+len, 60). No FCS is emitted. All multi-byte fields are big-endian.
- `id` is a 16-bit counter. It resets to 0 and increments (wrapping at 0xFFFF→0) after each emitted frame.
- After `lastByte`, return to IDLE.
- `start` while `busy` is ignored: no error pulse, and the frame in progress is unaffected.
- `inValid` outside LOAD is ignored.

## Timing
- Reset values: `inReady`=0, `dataValid`=0, `data`=0, `newpkt`=0, `lastByte`=0, `busy`=0, `error`=0, id=0, state IDLE.
- Reset mid-frame clears state immediately. A partial frame is simply truncated; the next frame starts cleanly.
- `busy` rises the cycle after `start` is accepted. It falls the cycle after `lastByte`.
- `inReady` rises the cycle after start when `len > 0`. It falls the cycle after the `len`-th accepted byte.
- First output byte (`newpkt`=1) comes exactly 3 cycles after the cycle that accepted the last payload byte. For `len == 0` it comes 3 cycles after the start cycle.
- `dataValid` is continuous for the whole frame. There is no output back-pressure.
- A new `start` is accepted on the first cycle `busy` is low.
- `error` is asserted on the cycle after the rejected `start`.

## Test plan
- SYN, len=0, flags=0x02: src 10.210.50.28:57284, dst 10.210.144.11:4846.
  - Frame is 60 bytes; bytes 54..59 are 0x00; `newpkt` on byte 0; `lastByte` on byte 59.
  - One's-complement sum over bytes 14..33 is 0xFFFF.
- Loopback: same tuple, len=1, payload 0x20, `mac`=48'hC471FEC856BF as `dst_mac`, output fed into a Tcp instance (port 80, same mac) with tcpA set to that tuple.
  - `outDataMatchA` pulses exactly once, with `outData`=0x20.
- len=3, payload 41 42 43.
  - Frame is 60 bytes, with 3 pad bytes.
  - TCP checksum verifies: the sum over the pseudo-header, TCP header and odd-padded payload folds to 0xFFFF.
- len=64 with `inValid` toggling every other cycle.
  - `inReady` stays high through the gaps.
  - 118-byte frame; first byte 3 cycles after the 64th accepted byte.
  - A second frame carries IP id = 1.
- len=65: `error` pulse, `busy` stays 0, no `dataValid`. A `start` during EMIT produces no effect.
- `RESET` asserted at frame byte 30.
  - Outputs go to 0 immediately.
  - The next frame is complete, with IP id = 0.
